// File: rtl/mux32_arbiter_pkg.sv
// Shared constants, FSM state type and the rotating priority pick
// used by the 32-port round-robin arbiter.
package mux32_arbiter_pkg;

  localparam int NUM_PORTS = 32;
  localparam int SEL_W     = 5;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } grant_t;

  // Walk from the farthest offset back to ptr so the nearest active index wins.
  function automatic grant_t rr_pick(input logic [NUM_PORTS-1:0] req,
                                     input logic [SEL_W-1:0]     ptr);
    grant_t           g;
    logic [SEL_W-1:0] idx;
    g = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) begin
        g.found = 1'b1;
        g.idx   = idx;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/mux32_arbiter_mux32.sv
// Plain 32:1 word selector for the arbiter's data path.
module mux32
  import mux32_arbiter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]     in_i [NUM_PORTS],
  input  logic [SEL_W-1:0] sel_i,
  output logic [N-1:0]     data_o
);

  always_comb begin
    data_o = in_i[sel_i];
  end

endmodule

// File: rtl/mux32_arbiter.sv
// 32-requester round-robin arbiter feeding a single registered output
// word with valid/ready handshake; the held word is the only buffering.
module mux32_arbiter
  import mux32_arbiter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_PORTS-1:0]   req,
  input  logic [NUM_PORTS*N-1:0] in_data,
  output logic [NUM_PORTS-1:0]   ack,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           out_data,
  output logic [SEL_W-1:0]       out_id
);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0] out_id_q, out_id_d;

  state_e       state;
  grant_t       grant;
  logic         can_load;
  logic [N-1:0] slices [NUM_PORTS];
  logic [N-1:0] mux_data;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slice
    assign slices[i] = in_data[i*N +: N];
  end

  mux32 #(.N(N)) u_mux (
    .in_i  (slices),
    .sel_i (grant.idx),
    .data_o(mux_data)
  );

  assign state    = out_valid_q ? FULL : EMPTY;
  assign can_load = (state == EMPTY) || out_ready;

  always_comb begin
    grant = rr_pick(req, ptr_q);
  end

  // Gating with rst_n keeps ack quiet during reset even though can_load is high.
  always_comb begin
    ack = '0;
    if (rst_n && can_load && grant.found) begin
      ack[grant.idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    if (can_load) begin
      if (grant.found) begin
        out_valid_d = 1'b1;
        out_data_d  = mux_data;
        out_id_d    = grant.idx;
        ptr_d       = grant.idx + SEL_W'(1);
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_mux32_arbiter.sv
// Self-checking bench for mux32_arbiter: directed vector table, random
// traffic against a queue-free round-robin model, and corner sequences.
module tb_mux32_arbiter;

  localparam int N = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [31:0]     req;
  logic [32*N-1:0] in_data;
  logic [31:0]     ack;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    out_data;
  logic [4:0]      out_id;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int          m_ptr;
  logic        m_valid;
  logic [7:0]  m_data;
  int          m_id;

  mux32_arbiter #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .in_data  (in_data),
    .ack      (ack),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_id   (out_id)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dpat(input int i);
    return 8'hA5 + 8'(i * 7);
  endfunction

  task automatic load_pattern();
    for (int i = 0; i < 32; i++) in_data[i*N +: N] = dpat(i);
  endtask

  function automatic int pick(input logic [31:0] r, input int p);
    for (int k = 0; k < 32; k++)
      if (r[(p + k) % 32]) return (p + k) % 32;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_data = 8'h00; m_id = 0;
  endtask

  // One clock: drive at negedge, check ack mid-cycle, check registers after posedge.
  task automatic step(input logic [31:0] r, input logic rdy, output logic [31:0] ack_seen);
    int          win;
    logic        can;
    logic [31:0] exp_ack;
    @(negedge clk);
    req = r;
    out_ready = rdy;
    #1;
    can = !m_valid || rdy;
    win = pick(r, m_ptr);
    exp_ack = (can && win >= 0) ? (32'h1 << win) : 32'h0;
    ack_seen = ack;
    chk("ack", ack, exp_ack);
    n_assert++;
    if ($countones(ack) > 1) begin
      n_fail++;
      $display("FAIL ack_onehot: got %h expected at most one bit", ack);
    end
    @(posedge clk);
    if (can) begin
      if (win >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[win*N +: N];
        m_id    = win;
        m_ptr   = (win + 1) % 32;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    chk("out_data", {24'b0, out_data}, {24'b0, m_data});
    chk("out_id", {27'b0, out_id}, 32'(m_id));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 32'hFFFF_FFFF;
    #1;
    chk("rst_ack", ack, 32'h0);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 32'h0;
    model_reset();
  endtask

  typedef struct {
    logic [31:0] req;
    logic        rdy;
    logic [31:0] ack;
    logic        valid;
    logic [4:0]  id;
    logic [7:0]  data;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [31:0] a;
    rst_n = 1'b0;
    req = 32'hFFFF_FFFF;
    out_ready = 1'b1;
    load_pattern();
    model_reset();
    #7;
    chk("reset_ack", ack, 32'h0);
    chk("reset_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_data", {24'b0, out_data}, 32'h0);
    chk("reset_id", {27'b0, out_id}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 32'h0;

    // Directed table starting from ptr=0, EMPTY.
    tbl[0] = '{32'h0000_0001, 1'b1, 32'h0000_0001, 1'b1, 5'd0,  dpat(0)};
    tbl[1] = '{32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 5'd0,  dpat(0)};
    tbl[2] = '{32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1, 5'd31, dpat(31)};
    tbl[3] = '{32'h0000_0009, 1'b0, 32'h0000_0000, 1'b1, 5'd31, dpat(31)};
    tbl[4] = '{32'h0000_0009, 1'b1, 32'h0000_0001, 1'b1, 5'd0,  dpat(0)};
    tbl[5] = '{32'h0000_0009, 1'b1, 32'h0000_0008, 1'b1, 5'd3,  dpat(3)};
    tbl[6] = '{32'h0000_0009, 1'b1, 32'h0000_0001, 1'b1, 5'd0,  dpat(0)};
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].req, tbl[i].rdy, a);
      chk($sformatf("tbl%0d_ack", i), a, tbl[i].ack);
      chk($sformatf("tbl%0d_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].valid});
      chk($sformatf("tbl%0d_id", i), {27'b0, out_id}, {27'b0, tbl[i].id});
      chk($sformatf("tbl%0d_data", i), {24'b0, out_data}, {24'b0, tbl[i].data});
    end

    // Fairness: all requesting, ready high, ids must count 0..31 twice.
    do_reset();
    for (int k = 0; k < 64; k++) begin
      step(32'hFFFF_FFFF, 1'b1, a);
      chk("fair_id", {27'b0, out_id}, 32'(k % 32));
    end

    // Wrap: 3 and 30 active with ptr parked at 31.
    do_reset();
    step(32'h4000_0000, 1'b1, a);
    chk("wrap_seed", a, 32'h4000_0000);
    step(32'h4000_0008, 1'b1, a);
    chk("wrap_g3", {27'b0, out_id}, 32'd3);
    step(32'h4000_0008, 1'b1, a);
    chk("wrap_g30", {27'b0, out_id}, 32'd30);
    step(32'h4000_0008, 1'b1, a);
    chk("wrap_g3b", {27'b0, out_id}, 32'd3);

    // Stall with id 7 held, then release.
    step(32'h0000_0080, 1'b1, a);
    chk("stall_seed", {27'b0, out_id}, 32'd7);
    for (int k = 0; k < 5; k++) begin
      step(32'h0000_00FF, 1'b0, a);
      chk("stall_ack", a, 32'h0);
      chk("stall_id", {27'b0, out_id}, 32'd7);
      chk("stall_data", {24'b0, out_data}, {24'b0, dpat(7)});
    end
    step(32'h0000_00FF, 1'b1, a);
    chk("stall_release_ack", a, 32'h0000_0001);

    // Drain to EMPTY, then grant 31 and confirm ptr wrapped to 0.
    step(32'h0, 1'b1, a);
    chk("drain_valid", {31'b0, out_valid}, 32'h0);
    step(32'h8000_0000, 1'b1, a);
    chk("g31_ack", a, 32'h8000_0000);
    step(32'h8000_0001, 1'b1, a);
    chk("after31_ack", a, 32'h0000_0001);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] r;
      for (int j = 0; j < 32; j++) in_data[j*N +: N] = 8'($urandom);
      case ($urandom_range(0, 3))
        0: r = 32'h0;
        1: r = 32'h1 << $urandom_range(0, 31);
        2: r = $urandom & $urandom;
        default: r = $urandom;
      endcase
      step(r, 1'($urandom_range(0, 3) != 0), a);
    end

    // Asynchronous reset mid-cycle while FULL.
    load_pattern();
    step(32'h0000_0400, 1'b1, a);
    @(negedge clk);
    req = 32'h0000_00FF;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'h0);
    chk("arst_data", {24'b0, out_data}, 32'h0);
    chk("arst_id", {27'b0, out_id}, 32'h0);
    chk("arst_ack", ack, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(32'h0000_0050, 1'b1, a);
    chk("arst_first_grant", a, 32'h0000_0010);
    chk("arst_first_id", {27'b0, out_id}, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
